io_controller: RTL and testbench

IO_CONTROLLER -- requirements
Module: io_controller

---
 rtl/io_controller_if.sv | 13 +
 rtl/io_controller.sv | 108 ++++++++++
 tb/tb_io_controller.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_controller_if.sv
// Processor data-bus connection between the CPU and the memory-mapped I/O block.
interface io_controller_if #(parameter int DBITS = 32);
  logic [DBITS-1:0] addr;
  logic [DBITS-1:0] wdata;
  logic             we;
  logic             re;
  logic [DBITS-1:0] rdata;
  logic             rvalid;
  logic             is_io;

  modport master (output addr, wdata, we, re, input rdata, rvalid, is_io);
  modport slave  (input addr, wdata, we, re, output rdata, rvalid, is_io);
endinterface

// File: rtl/io_controller.sv
// Memory-mapped I/O for the DE-board: HEX/LEDR/LEDG output registers,
// synchronized KEY/SW inputs with ready/overrun status registers.
module io_controller #(
  parameter int               DBITS      = 32,
  parameter logic [DBITS-1:0] ADDR_HEX   = 32'hF0000000,
  parameter logic [DBITS-1:0] ADDR_LEDR  = 32'hF0000004,
  parameter logic [DBITS-1:0] ADDR_LEDG  = 32'hF0000008,
  parameter logic [DBITS-1:0] ADDR_KEY   = 32'hF0000010,
  parameter logic [DBITS-1:0] ADDR_SW    = 32'hF0000014,
  parameter logic [DBITS-1:0] ADDR_KCTRL = 32'hF0000110,
  parameter logic [DBITS-1:0] ADDR_SCTRL = 32'hF0000114
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  io_controller_if.slave bus,
  input  logic [3:0]  KEY,
  input  logic [9:0]  SW,
  output logic [15:0] HEX,
  output logic [9:0]  LEDR,
  output logic [7:0]  LEDG
);

  // KEY is inverted before the first stage so a reset value of 0 means "released".
  logic [3:0] key_meta, ksync, ksync_prev;
  logic [9:0] sw_meta, ssync, ssync_prev;
  logic       k_ready, k_overrun, s_ready, s_overrun;
  logic       key_event, sw_event;
  logic       ld_key, ld_sw, clr_kovr, clr_sovr;
  logic [DBITS-1:0] read_val;
  logic       unused_wdata;

  assign bus.is_io = (bus.addr[31:12] == 20'hF0000);

  assign key_event = (ksync != ksync_prev);
  assign sw_event  = (ssync != ssync_prev);
  assign ld_key    = bus.re && (bus.addr == ADDR_KEY);
  assign ld_sw     = bus.re && (bus.addr == ADDR_SW);
  assign clr_kovr  = bus.we && (bus.addr == ADDR_KCTRL) && !bus.wdata[2];
  assign clr_sovr  = bus.we && (bus.addr == ADDR_SCTRL) && !bus.wdata[2];

  assign unused_wdata = ^bus.wdata[DBITS-1:16];

  // Full-address decode; any non-I/O address misses every case and reads 0.
  always_comb begin
    read_val = '0;
    case (bus.addr)
      ADDR_HEX:   read_val[15:0] = HEX;
      ADDR_LEDR:  read_val[9:0]  = LEDR;
      ADDR_LEDG:  read_val[7:0]  = LEDG;
      ADDR_KEY:   read_val[3:0]  = ksync;
      ADDR_SW:    read_val[9:0]  = ssync;
      ADDR_KCTRL: read_val[2:0]  = {k_overrun, 1'b0, k_ready};
      ADDR_SCTRL: read_val[2:0]  = {s_overrun, 1'b0, s_ready};
      default:    read_val       = '0;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      key_meta   <= '0;
      ksync      <= '0;
      ksync_prev <= '0;
      sw_meta    <= '0;
      ssync      <= '0;
      ssync_prev <= '0;
      k_ready    <= 1'b0;
      k_overrun  <= 1'b0;
      s_ready    <= 1'b0;
      s_overrun  <= 1'b0;
      HEX        <= '0;
      LEDR       <= '0;
      LEDG       <= '0;
      bus.rdata  <= '0;
      bus.rvalid <= 1'b0;
    end else begin
      key_meta   <= ~KEY;
      ksync      <= key_meta;
      ksync_prev <= ksync;
      sw_meta    <= SW;
      ssync      <= sw_meta;
      ssync_prev <= ssync;

      if (bus.we) begin
        case (bus.addr)
          ADDR_HEX:  HEX  <= bus.wdata[15:0];
          ADDR_LEDR: LEDR <= bus.wdata[9:0];
          ADDR_LEDG: LEDG <= bus.wdata[7:0];
          default:   ;
        endcase
      end

      // A change event beats any same-cycle clear of ready or overrun.
      if (key_event)   k_ready <= 1'b1;
      else if (ld_key) k_ready <= 1'b0;
      if (key_event && k_ready) k_overrun <= 1'b1;
      else if (clr_kovr)        k_overrun <= 1'b0;

      if (sw_event)   s_ready <= 1'b1;
      else if (ld_sw) s_ready <= 1'b0;
      if (sw_event && s_ready) s_overrun <= 1'b1;
      else if (clr_sovr)       s_overrun <= 1'b0;

      bus.rvalid <= bus.re;
      if (bus.re) bus.rdata <= read_val;
    end
  end

endmodule

// File: tb/tb_io_controller.sv
// Self-checking bench for io_controller: directed scenarios plus a randomized
// run compared against a behavioural model of the I/O register map.
module tb_io_controller;
  localparam int DBITS = 32;
  localparam logic [31:0] A_HEX   = 32'hF0000000;
  localparam logic [31:0] A_LEDR  = 32'hF0000004;
  localparam logic [31:0] A_LEDG  = 32'hF0000008;
  localparam logic [31:0] A_KEY   = 32'hF0000010;
  localparam logic [31:0] A_SW    = 32'hF0000014;
  localparam logic [31:0] A_KCTRL = 32'hF0000110;
  localparam logic [31:0] A_SCTRL = 32'hF0000114;

  logic        CLOCK_50 = 1'b0;
  logic        RESET    = 1'b1;
  logic [3:0]  KEY      = 4'hF;
  logic [9:0]  SW       = '0;
  logic [15:0] HEX;
  logic [9:0]  LEDR;
  logic [7:0]  LEDG;

  int checks = 0;
  int errors = 0;

  io_controller_if #(.DBITS(DBITS)) bus ();

  io_controller #(.DBITS(DBITS)) dut (
    .CLOCK_50(CLOCK_50),
    .RESET(RESET),
    .bus(bus),
    .KEY(KEY),
    .SW(SW),
    .HEX(HEX),
    .LEDR(LEDR),
    .LEDG(LEDG)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Behavioural model: register values plus a history of "pressed"/switch
  // samples; an input is visible two edges after it is sampled.
  logic [15:0] m_hex;
  logic [9:0]  m_ledr;
  logic [7:0]  m_ledg;
  logic        m_kr, m_ko, m_sr, m_so;
  logic [31:0] m_rdata;
  logic        m_rvalid;
  logic [3:0]  k_hist [3];
  logic [9:0]  s_hist [3];

  initial begin
    m_hex = '0; m_ledr = '0; m_ledg = '0;
    m_kr = 0; m_ko = 0; m_sr = 0; m_so = 0;
    m_rdata = '0; m_rvalid = 0;
    for (int i = 0; i < 3; i++) begin k_hist[i] = '0; s_hist[i] = '0; end
  end

  function automatic logic [31:0] model_read(input logic [31:0] a);
    case (a)
      A_HEX:   return {16'b0, m_hex};
      A_LEDR:  return {22'b0, m_ledr};
      A_LEDG:  return {24'b0, m_ledg};
      A_KEY:   return {28'b0, k_hist[1]};
      A_SW:    return {22'b0, s_hist[1]};
      A_KCTRL: return {29'b0, m_ko, 1'b0, m_kr};
      A_SCTRL: return {29'b0, m_so, 1'b0, m_sr};
      default: return 32'b0;
    endcase
  endfunction

  task automatic model_step();
    logic kev, sev, nkr, nko, nsr, nso;
    if (RESET) begin
      m_hex = '0; m_ledr = '0; m_ledg = '0;
      m_kr = 0; m_ko = 0; m_sr = 0; m_so = 0;
      m_rdata = '0; m_rvalid = 0;
      for (int i = 0; i < 3; i++) begin k_hist[i] = '0; s_hist[i] = '0; end
    end else begin
      kev = (k_hist[1] != k_hist[2]);
      sev = (s_hist[1] != s_hist[2]);
      if (bus.re) m_rdata = model_read(bus.addr);
      m_rvalid = bus.re;
      nkr = kev ? 1'b1 : ((bus.re && bus.addr == A_KEY) ? 1'b0 : m_kr);
      nsr = sev ? 1'b1 : ((bus.re && bus.addr == A_SW) ? 1'b0 : m_sr);
      nko = (kev && m_kr) ? 1'b1 : ((bus.we && bus.addr == A_KCTRL && !bus.wdata[2]) ? 1'b0 : m_ko);
      nso = (sev && m_sr) ? 1'b1 : ((bus.we && bus.addr == A_SCTRL && !bus.wdata[2]) ? 1'b0 : m_so);
      m_kr = nkr; m_ko = nko; m_sr = nsr; m_so = nso;
      if (bus.we && bus.addr == A_HEX)  m_hex  = bus.wdata[15:0];
      if (bus.we && bus.addr == A_LEDR) m_ledr = bus.wdata[9:0];
      if (bus.we && bus.addr == A_LEDG) m_ledg = bus.wdata[7:0];
      k_hist[2] = k_hist[1]; k_hist[1] = k_hist[0]; k_hist[0] = ~KEY;
      s_hist[2] = s_hist[1]; s_hist[1] = s_hist[0]; s_hist[0] = SW;
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    model_step();
    @(negedge CLOCK_50);
  endtask

  task automatic idle();
    bus.addr = '0; bus.wdata = '0; bus.we = 1'b0; bus.re = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.addr = a; bus.wdata = d; bus.we = 1'b1; bus.re = 1'b0;
    tick();
    idle();
  endtask

  task automatic load(input logic [31:0] a, output logic [31:0] rd, output logic rv);
    bus.addr = a; bus.wdata = '0; bus.we = 1'b0; bus.re = 1'b1;
    tick();
    rd = bus.rdata; rv = bus.rvalid;
    idle();
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic rv;
    RESET = 1'b1; KEY = 4'hF; SW = '0; idle();
    repeat (3) tick();
    RESET = 1'b0;
    tick();
    checks++; if (HEX !== 16'h0) begin errors++; $display("[TB] FAIL reset_hex got %h want 0", HEX); end
    checks++; if (LEDR !== 10'h0) begin errors++; $display("[TB] FAIL reset_ledr got %h want 0", LEDR); end
    checks++; if (LEDG !== 8'h0) begin errors++; $display("[TB] FAIL reset_ledg got %h want 0", LEDG); end
    checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rvalid got %b want 0", bus.rvalid); end
    checks++; if (bus.rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata got %h want 0", bus.rdata); end
    repeat (3) tick();
    load(A_KCTRL, rd, rv);
    checks++; if (rd !== 32'h0 || rv !== 1'b1) begin errors++; $display("[TB] FAIL reset_kctrl got %h/%b want 0/1", rd, rv); end
  endtask

  task automatic test_store();
    logic [31:0] rd; logic rv;
    store(A_HEX, 32'h1234);
    store(A_LEDR, 32'h3FF);
    checks++; if (HEX !== 16'h1234) begin errors++; $display("[TB] FAIL store_hex got %h want 1234", HEX); end
    checks++; if (LEDR !== 10'h3FF) begin errors++; $display("[TB] FAIL store_ledr got %h want 3ff", LEDR); end
    checks++; if (LEDG !== 8'h0) begin errors++; $display("[TB] FAIL store_ledg got %h want 0", LEDG); end
    store(A_KEY, 32'hFFFF_FFFF);
    store(32'hF0000020, 32'hFFFF_FFFF);
    store(32'h0000_0000, 32'hFFFF_FFFF);
    checks++; if (HEX !== 16'h1234 || LEDR !== 10'h3FF || LEDG !== 8'h0) begin
      errors++; $display("[TB] FAIL store_ignored got %h/%h/%h want 1234/3ff/00", HEX, LEDR, LEDG); end
    load(A_HEX, rd, rv);
    checks++; if (rd !== 32'h1234) begin errors++; $display("[TB] FAIL load_hex got %h want 1234", rd); end
  endtask

  task automatic test_sw();
    logic [31:0] rd; logic rv;
    SW = 10'b1111000001;
    repeat (3) tick();
    load(A_SCTRL, rd, rv);
    checks++; if (rd !== 32'h1) begin errors++; $display("[TB] FAIL sctrl_ready got %h want 1", rd); end
    load(A_SW, rd, rv);
    checks++; if (rd !== 32'h3C1) begin errors++; $display("[TB] FAIL sw_load got %h want 3c1", rd); end
    load(A_SCTRL, rd, rv);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL sctrl_cleared got %h want 0", rd); end
  endtask

  task automatic test_key();
    logic [31:0] rd; logic rv;
    KEY = 4'b1110;
    repeat (3) tick();
    KEY = 4'b1010;
    repeat (3) tick();
    load(A_KCTRL, rd, rv);
    checks++; if (rd !== 32'h5) begin errors++; $display("[TB] FAIL kctrl_overrun got %h want 5", rd); end
    store(A_KCTRL, 32'h0);
    load(A_KCTRL, rd, rv);
    checks++; if (rd !== 32'h1) begin errors++; $display("[TB] FAIL kctrl_clear_ovr got %h want 1", rd); end
    load(A_KEY, rd, rv);
    checks++; if (rd !== 32'h5) begin errors++; $display("[TB] FAIL key_load got %h want 5", rd); end
  endtask

  task automatic test_set_wins();
    logic [31:0] rd; logic rv;
    KEY = 4'b1000;
    repeat (2) tick();
    load(A_KEY, rd, rv);
    checks++; if (rd !== 32'h7) begin errors++; $display("[TB] FAIL setwin_key got %h want 7", rd); end
    load(A_KCTRL, rd, rv);
    checks++; if (rd !== 32'h1) begin errors++; $display("[TB] FAIL setwin_ready got %h want 1", rd); end
    load(A_KEY, rd, rv);
  endtask

  task automatic test_non_io();
    logic [31:0] rd; logic rv;
    bus.addr = 32'h0000_0100; #1;
    checks++; if (bus.is_io !== 1'b0) begin errors++; $display("[TB] FAIL is_io_low got %b want 0", bus.is_io); end
    bus.addr = A_LEDR; #1;
    checks++; if (bus.is_io !== 1'b1) begin errors++; $display("[TB] FAIL is_io_high got %b want 1", bus.is_io); end
    idle();
    store(32'h0000_0100, 32'hDEAD_BEEF);
    load(32'h0000_0100, rd, rv);
    checks++; if (rv !== 1'b1 || rd !== 32'h0) begin errors++; $display("[TB] FAIL nonio_load got %h/%b want 0/1", rd, rv); end
    checks++; if (HEX !== m_hex || LEDR !== m_ledr || LEDG !== m_ledg) begin
      errors++; $display("[TB] FAIL nonio_regs got %h/%h/%h want %h/%h/%h", HEX, LEDR, LEDG, m_hex, m_ledr, m_ledg); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_list [3];
    logic [31:0] addr_list [3];
    addr_list[0] = A_LEDG; addr_list[1] = A_HEX; addr_list[2] = A_LEDR;
    exp_list[0] = 32'h0;   exp_list[1] = 32'h1234; exp_list[2] = 32'h3FF;
    for (int i = 0; i < 3; i++) begin
      bus.addr = addr_list[i]; bus.re = 1'b1; bus.we = 1'b0;
      tick();
      checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== exp_list[i]) begin
        errors++; $display("[TB] FAIL b2b_%0d got %h/%b want %h/1", i, bus.rdata, bus.rvalid, exp_list[i]); end
    end
    idle();
    tick();
    checks++; if (bus.rvalid !== 1'b0 || bus.rdata !== 32'h3FF) begin
      errors++; $display("[TB] FAIL rdata_hold got %h/%b want 3ff/0", bus.rdata, bus.rvalid); end
    bus.addr = A_LEDR; bus.wdata = 32'h155; bus.we = 1'b1; bus.re = 1'b1;
    tick();
    idle();
    checks++; if (bus.rdata !== 32'h3FF || LEDR !== 10'h155) begin
      errors++; $display("[TB] FAIL rw_same got %h/%h want 3ff/155", bus.rdata, LEDR); end
  endtask

  task automatic test_reset_mid_load();
    store(A_LEDR, 32'h2AA);
    checks++; if (LEDR !== 10'h2AA) begin errors++; $display("[TB] FAIL ledr_2aa got %h want 2aa", LEDR); end
    bus.addr = A_LEDR; bus.re = 1'b1; RESET = 1'b1;
    tick();
    checks++; if (bus.rvalid !== 1'b0 || LEDR !== 10'h0) begin
      errors++; $display("[TB] FAIL reset_mid_load got %b/%h want 0/000", bus.rvalid, LEDR); end
    RESET = 1'b0; idle();
    tick();
  endtask

  task automatic applyStimulus_random();
    logic [31:0] alist [9];
    alist[0] = A_HEX; alist[1] = A_LEDR; alist[2] = A_LEDG; alist[3] = A_KEY;
    alist[4] = A_SW;  alist[5] = A_KCTRL; alist[6] = A_SCTRL; alist[7] = 32'hF0000020;
    for (int n = 0; n < 500; n++) begin
      RESET = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 7) == 0) KEY = 4'($urandom);
      if ($urandom_range(0, 7) == 0) SW = 10'($urandom);
      alist[8] = $urandom & 32'h0FFF_FFFF;
      bus.addr  = alist[$urandom_range(0, 8)];
      bus.wdata = $urandom;
      bus.we    = $urandom_range(0, 1) == 1;
      bus.re    = $urandom_range(0, 1) == 1;
      tick();
      checks++; if (HEX !== m_hex) begin errors++; $display("[TB] FAIL rnd_hex %0d got %h want %h", n, HEX, m_hex); end
      checks++; if (LEDR !== m_ledr) begin errors++; $display("[TB] FAIL rnd_ledr %0d got %h want %h", n, LEDR, m_ledr); end
      checks++; if (LEDG !== m_ledg) begin errors++; $display("[TB] FAIL rnd_ledg %0d got %h want %h", n, LEDG, m_ledg); end
      checks++; if (bus.rvalid !== m_rvalid) begin errors++; $display("[TB] FAIL rnd_rvalid %0d got %b want %b", n, bus.rvalid, m_rvalid); end
      checks++; if (bus.rdata !== m_rdata) begin errors++; $display("[TB] FAIL rnd_rdata %0d got %h want %h", n, bus.rdata, m_rdata); end
    end
    RESET = 1'b0; idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_store();
    test_sw();
    test_key();
    test_set_wins();
    test_non_io();
    test_back_to_back();
    test_reset_mid_load();
    applyStimulus_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
